// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: decodes framed read/write/ping commands from the
// receive byte stream, runs one bus transaction, and returns response bytes.
module uart_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_out,
  input  logic [31:0] bus_in,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wr_mask,
  input  logic        bus_ack,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  localparam logic [7:0]  OP_READ  = 8'h52;
  localparam logic [7:0]  OP_WRITE = 8'h57;
  localparam logic [7:0]  OP_PING  = 8'h50;
  localparam logic [7:0]  RSP_OK   = 8'h4B;
  localparam logic [7:0]  RSP_BAD  = 8'h3F;
  localparam logic [7:0]  RSP_ERR  = 8'h45;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [1:0]  cnt, cnt_next;
  logic        is_write, is_write_next;
  logic [31:0] addr, addr_next;
  logic [31:0] wdata, wdata_next;
  logic [23:0] rdata, rdata_next;
  logic [15:0] tmo, tmo_next;
  logic [1:0]  resp_left, resp_left_next;
  logic [7:0]  tx_data_next;
  logic        tx_valid_next;
  logic        bus_req_next;
  logic        bus_wr_next;
  logic [3:0]  bus_wr_mask_next;
  logic [31:0] bus_addr_next;
  logic [31:0] bus_out_next;
  logic        start_bus;

  // Next-state and next-output computation for every register.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    is_write_next    = is_write;
    addr_next        = addr;
    wdata_next       = wdata;
    rdata_next       = rdata;
    tmo_next         = tmo;
    resp_left_next   = resp_left;
    tx_data_next     = tx_data;
    tx_valid_next    = tx_valid;
    bus_req_next     = bus_req;
    bus_wr_next      = bus_wr;
    bus_wr_mask_next = bus_wr_mask;
    bus_addr_next    = bus_addr;
    bus_out_next     = bus_out;
    start_bus        = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_READ, OP_WRITE: begin
              state_next    = ADDR;
              cnt_next      = 2'd0;
              is_write_next = (rx_data == OP_WRITE);
            end
            OP_PING: begin
              state_next     = RESP;
              tx_valid_next  = 1'b1;
              tx_data_next   = RSP_OK;
              resp_left_next = 2'd0;
            end
            default: begin
              state_next     = RESP;
              tx_valid_next  = 1'b1;
              tx_data_next   = RSP_BAD;
              resp_left_next = 2'd0;
            end
          endcase
        end else begin
          state_next = IDLE;
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_next[{cnt, 3'b000} +: 8] = rx_data;
          cnt_next = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_write) begin
              state_next = DATA;
            end else begin
              state_next = BUS;
              start_bus  = 1'b1;
            end
          end else begin
            state_next = ADDR;
          end
        end else begin
          state_next = ADDR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_next[{cnt, 3'b000} +: 8] = rx_data;
          cnt_next = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_next = BUS;
            start_bus  = 1'b1;
          end else begin
            state_next = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
      BUS: begin
        // Ack wins over timeout when both land on the same cycle.
        if (bus_ack) begin
          bus_req_next  = 1'b0;
          state_next    = RESP;
          tx_valid_next = 1'b1;
          if (is_write) begin
            tx_data_next   = RSP_OK;
            resp_left_next = 2'd0;
          end else begin
            rdata_next     = bus_in[31:8];
            tx_data_next   = bus_in[7:0];
            resp_left_next = 2'd3;
          end
        end else if (tmo == TMO_LAST) begin
          bus_req_next   = 1'b0;
          state_next     = RESP;
          tx_valid_next  = 1'b1;
          tx_data_next   = RSP_ERR;
          resp_left_next = 2'd0;
        end else begin
          tmo_next = tmo + 16'd1;
        end
      end
      RESP: begin
        if (tx_ready) begin
          if (resp_left == 2'd0) begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end else begin
            resp_left_next = resp_left - 2'd1;
            tx_data_next   = rdata[7:0];
            rdata_next     = {8'h00, rdata[23:8]};
          end
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next    = IDLE;
        tx_valid_next = 1'b0;
        bus_req_next  = 1'b0;
      end
    endcase

    if (start_bus) begin
      bus_req_next     = 1'b1;
      bus_addr_next    = {addr_next[31:2], 2'b00};
      bus_wr_next      = is_write;
      bus_wr_mask_next = is_write ? 4'hf : 4'h0;
      bus_out_next     = is_write ? wdata_next : bus_out;
      tmo_next         = 16'd0;
    end else begin
      bus_req_next = bus_req_next;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      is_write    <= 1'b0;
      addr        <= 32'h0;
      wdata       <= 32'h0;
      rdata       <= 24'h0;
      tmo         <= 16'd0;
      resp_left   <= 2'd0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      bus_req     <= 1'b0;
      bus_wr      <= 1'b0;
      bus_wr_mask <= 4'h0;
      bus_addr    <= 32'h0;
      bus_out     <= 32'h0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      is_write    <= is_write_next;
      addr        <= addr_next;
      wdata       <= wdata_next;
      rdata       <= rdata_next;
      tmo         <= tmo_next;
      resp_left   <= resp_left_next;
      tx_data     <= tx_data_next;
      tx_valid    <= tx_valid_next;
      bus_req     <= bus_req_next;
      bus_wr      <= bus_wr_next;
      bus_wr_mask <= bus_wr_mask_next;
      bus_addr    <= bus_addr_next;
      bus_out     <= bus_out_next;
      busy        <= (state_next != IDLE);
    end
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Bus initiator driven by a byte stream from the UART receive path; lets a host read and write words on the SoC bus over the serial line for debug and firmware loading.
- Decodes framed commands, issues single-word bus transactions, and returns response bytes toward the UART transmit path.
- Drives the same req/ack bus the core drives; bus arbitration sits outside this block.

Parameters:
- TIMEOUT, 255: max cycles bus_req is held without bus_ack before abort; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- tx_data  out  8  response byte, held stable while tx_valid=1
- tx_valid  out  1  response byte available
- tx_ready  in  1  sink accepts byte; transfer occurs on a cycle with tx_valid & tx_ready
- bus_addr  out  32  transaction address; bits [1:0] always 0
- bus_out  out  32  write data
- bus_in  in  32  read data, sampled on the ack cycle
- bus_req  out  1  transaction request
- bus_wr  out  1  1=write, 0=read
- bus_wr_mask  out  4  byte enables; 4'hf on writes, 4'h0 on reads
- bus_ack  in  1  responder completion
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; tx_valid=0, tx_data=0, bus_req=0, bus_wr=0, bus_wr_mask=0, bus_addr=0, bus_out=0, busy=0; all counters and shift registers cleared. Reset mid-command or mid-transaction drops it immediately; no response is sent.
- Command framing (all multi-byte fields little-endian):
  - 0x52 'R' + A0..A3: read word; response D0..D3.
  - 0x57 'W' + A0..A3 + D0..D3: write word; response 0x4B 'K'.
  - 0x50 'P': ping; response 0x4B, no bus activity.
  - Any other opcode: response 0x3F '?'.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE: on rx_valid, decode opcode. R/W -> ADDR, byte counter=0. P -> RESP with 0x4B. Unknown -> RESP with 0x3F.
- ADDR: each rx_valid shifts a byte into addr[8*cnt+:8]. After the 4th byte: R -> BUS, W -> DATA.
- DATA: same as ADDR for write data; after the 4th byte -> BUS.
- BUS:
  - bus_req=1 on the first BUS cycle, i.e. the cycle after the last byte's rx_valid.
  - bus_addr = {addr[31:2],2'b00}, bus_wr, bus_wr_mask and bus_out are held constant while req=1.
  - Timeout counter starts at 0 when req first asserts and increments every cycle req=1 and ack=0.
  - On a cycle with req & ack: sample bus_in (reads), drop req next cycle, go to RESP. A same-cycle ack (zero wait) is legal, so minimum req width is 1 cycle.
  - If the counter reaches TIMEOUT without ack: drop req, go to RESP with single byte 0x45 'E'. A late ack arriving after req drops is ignored.
- RESP:
  - tx_valid=1 with the current byte; it advances only on tx_valid & tx_ready.
  - Read: 4 bytes D0 first; every other response is 1 byte.
  - After the last accepted byte: tx_valid=0 next cycle, state -> IDLE.
  - tx_ready held low stalls indefinitely; tx_data must not change while stalled.
- rx_valid in BUS or RESP: byte discarded, no state effect (host must await the response).
- rx_valid coincident with the transition into IDLE is not decoded; a byte is decoded only when the state is already IDLE.
- Outputs are registered; no combinational path from rx or bus_in to any output.

Test Plan:
- Read: after reset send 52 00 00 00 00, responder acks 2 cycles after req with bus_in=0xDEADBEEF -> bus_addr=0, bus_wr=0, mask=0; tx bytes EF BE AD DE; busy=0 afterwards.
- Write: send 57 00 00 00 80 01 00 00 00, zero-wait ack -> exactly one req cycle, bus_addr=0x80000000, bus_out=0x00000001, mask=4'hf, bus_wr=1; tx byte 4B.
- Unaligned/ping/unknown: read addr bytes 03 00 00 90 -> bus_addr=0x90000000. Send 50 -> 4B with no bus_req. Send 7A -> 3F.
- Timeout: TIMEOUT=8, read with ack tied 0 -> req high exactly 8 cycles then low; tx 45; an ack pulsed 3 cycles later causes no activity.
- Backpressure: during a read response hold tx_ready=0 for 10 cycles between bytes -> tx_data stable, no byte lost or duplicated; rx bytes sent during RESP are ignored.
- Reset mid-op: assert rst while in DATA after 2 data bytes, and again while bus_req=1 -> next cycle all outputs at reset values; a fresh ping returns 4B.
